// File: rtl/cnt_pkg.sv
// Shared types for the multi-channel counter/timer.
package cnt_pkg;

   // Encoding 2'b11 is reserved and treated as CNT_FREE by the channels.
   typedef enum logic [1:0] {
      CNT_FREE    = 2'd0,
      CNT_RELOAD  = 2'd1,
      CNT_ONESHOT = 2'd2
   } cnt_mode_e;

endpackage

// File: rtl/cnt_chan.sv
// One counter channel: count/event/done registers and next-value selection.
module cnt_chan
   import cnt_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             tick,
   input  logic             en,
   input  logic             clr,
   input  cnt_mode_e        mode,
   input  logic [WIDTH-1:0] cmp,
   output logic [WIDTH-1:0] cnt,
   output logic             cnt_end,
   output logic             evt,
   output logic             done
);

   logic [WIDTH-1:0] cnt_reg;
   logic [WIDTH-1:0] cnt_next;
   logic             evt_reg;
   logic             done_reg;
   logic             oneshot;
   logic             at_cmp;
   logic             hit;
   logic             step;

   assign oneshot  = (mode == CNT_ONESHOT);
   assign at_cmp   = (cnt_reg == cmp);
   assign step     = en & tick & ~clr & ~(oneshot & done_reg);
   assign cnt_next = ((mode == CNT_RELOAD) && at_cmp) ? '0 : cnt_reg + WIDTH'(1);
   assign hit      = (cnt_next == cmp);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_reg  <= '0;
         evt_reg  <= 1'b0;
         done_reg <= 1'b0;
      end else if (clr) begin
         cnt_reg  <= '0;
         evt_reg  <= 1'b0;
         done_reg <= 1'b0;
      end else begin
         evt_reg <= step & hit;
         if (step) begin
            // A one-shot already parked on its compare value finishes without counting.
            if (oneshot && at_cmp) begin
               done_reg <= 1'b1;
            end else begin
               cnt_reg <= cnt_next;
               if (oneshot && hit) begin
                  done_reg <= 1'b1;
               end
            end
         end
      end
   end

   assign cnt     = cnt_reg;
   assign cnt_end = at_cmp;
   assign evt     = evt_reg;
   assign done    = done_reg;

endmodule

// File: rtl/cnt_multi.sv
// Multi-channel counter/timer top: NUM_CH independent channels and a shared tick.
// Optional shared prescaler (and presc_i port) enabled by defining CNT_PRESCALER_EN.
module cnt_multi
   import cnt_pkg::*;
#(
   parameter int NUM_CH  = 4,
   parameter int WIDTH   = 32
`ifdef CNT_PRESCALER_EN
   ,
   parameter int PRESC_W = 8
`endif
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
`ifdef CNT_PRESCALER_EN
   input  logic [PRESC_W-1:0]           presc_i,
`endif
   input  logic [NUM_CH-1:0]            en_i,
   input  logic [NUM_CH-1:0]            clr_i,
   input  logic [NUM_CH-1:0][1:0]       mode_i,
   input  logic [NUM_CH-1:0][WIDTH-1:0] cmp_i,
   output logic [NUM_CH-1:0][WIDTH-1:0] cnt_o,
   output logic [NUM_CH-1:0]            cnt_end_o,
   output logic [NUM_CH-1:0]            evt_o,
   output logic [NUM_CH-1:0]            done_o
);

   logic tick;

`ifdef CNT_PRESCALER_EN
   logic [PRESC_W-1:0] presc_reg;

   // Comparing with >= lets a lowered presc_i take effect without a long wrap.
   assign tick = (presc_reg >= presc_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         presc_reg <= '0;
      end else if (tick) begin
         presc_reg <= '0;
      end else begin
         presc_reg <= presc_reg + PRESC_W'(1);
      end
   end
`else
   assign tick = 1'b1;
`endif

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
      cnt_chan #(
         .WIDTH (WIDTH)
      ) u_chan (
         .clk_i   (clk_i),
         .rst_ni  (rst_ni),
         .tick    (tick),
         .en      (en_i[gi]),
         .clr     (clr_i[gi]),
         .mode    (cnt_mode_e'(mode_i[gi])),
         .cmp     (cmp_i[gi]),
         .cnt     (cnt_o[gi]),
         .cnt_end (cnt_end_o[gi]),
         .evt     (evt_o[gi]),
         .done    (done_o[gi])
      );
   end

endmodule

// File: tb/tb_cnt_multi.sv
// Self-checking bench for cnt_multi: vector table on channel 0, free-running reference on channel 1.
module tb_cnt_multi;
   import cnt_pkg::*;

   localparam int NCH = 2;
   localparam int W   = 4;

   logic                     clk = 1'b0;
   logic                     rst_ni = 1'b0;
   logic [NCH-1:0]           en;
   logic [NCH-1:0]           clr;
   logic [NCH-1:0][1:0]      mode;
   logic [NCH-1:0][W-1:0]    cmp;
   logic [NCH-1:0][W-1:0]    cnt;
   logic [NCH-1:0]           cnt_end;
   logic [NCH-1:0]           evt;
   logic [NCH-1:0]           done;
`ifdef CNT_PRESCALER_EN
   logic [7:0]               presc = 8'd0;
`endif

   always #5 clk = ~clk;

   cnt_multi #(
      .NUM_CH (NCH),
      .WIDTH  (W)
   ) dut (
      .clk_i     (clk),
      .rst_ni    (rst_ni),
`ifdef CNT_PRESCALER_EN
      .presc_i   (presc),
`endif
      .en_i      (en),
      .clr_i     (clr),
      .mode_i    (mode),
      .cmp_i     (cmp),
      .cnt_o     (cnt),
      .cnt_end_o (cnt_end),
      .evt_o     (evt),
      .done_o    (done)
   );

   typedef struct {
      logic       en;
      logic       clr;
      logic [1:0] mode;
      logic [3:0] cmp;
      logic [3:0] ecnt;
      logic       eevt;
      logic       edone;
   } vec_t;

   typedef struct {
      logic [3:0] cnt0;
      logic       evt0;
      logic       done0;
      logic       end0;
      logic [3:0] cnt1;
      logic       evt1;
      int         id;
   } exp_t;

   vec_t       vecs[$];
   exp_t       exp_q[$];
   int         n_cmp = 0;
   int         n_bad = 0;
   logic [3:0] c1_model = 4'd0;
   int         n_main;
   int         n_rst;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, want);
      end
   endtask

   function automatic void add(input logic e, input logic c, input logic [1:0] m,
                               input logic [3:0] cp, input logic [3:0] ce,
                               input logic ev, input logic dn);
      vecs.push_back('{e, c, m, cp, ce, ev, dn});
   endfunction

   // Drive one vector for a cycle; channel 1 free-runs with cmp=5 beside it.
   task automatic run_vec(input vec_t v, input int id);
      exp_t x;
      exp_t got;
      en      = {1'b1, v.en};
      clr     = {1'b0, v.clr};
      mode[0] = v.mode;
      cmp[0]  = v.cmp;
      c1_model = c1_model + 4'd1;
      x.cnt0  = v.ecnt;
      x.evt0  = v.eevt;
      x.done0 = v.edone;
      x.end0  = (v.ecnt == v.cmp);
      x.cnt1  = c1_model;
      x.evt1  = (c1_model == 4'd5);
      x.id    = id;
      exp_q.push_back(x);
      @(posedge clk);
      #1;
      got = exp_q.pop_front();
      check($sformatf("v%0d cnt0", got.id), 32'(cnt[0]), 32'(got.cnt0));
      check($sformatf("v%0d evt0", got.id), 32'(evt[0]), 32'(got.evt0));
      check($sformatf("v%0d done0", got.id), 32'(done[0]), 32'(got.done0));
      check($sformatf("v%0d end0", got.id), 32'(cnt_end[0]), 32'(got.end0));
      check($sformatf("v%0d cnt1", got.id), 32'(cnt[1]), 32'(got.cnt1));
      check($sformatf("v%0d evt1", got.id), 32'(evt[1]), 32'(got.evt1));
      $display("vec %0d: ch0 cnt=%0d evt=%0d done=%0d end=%0d | ch1 cnt=%0d evt=%0d",
               got.id, cnt[0], evt[0], done[0], cnt_end[0], cnt[1], evt[1]);
   endtask

`ifdef CNT_PRESCALER_EN
   int last_chg;
   int last_evt;
   int n_evt;
   logic [3:0] prev_cnt;
`endif

   initial begin
      en   = '0;
      clr  = '0;
      mode = '0;
      cmp  = '0;
      cmp[1] = 4'd5;

      // Main table: channel 0 walks through every mode and corner case.
      add(0, 1, 0, 3, 0, 0, 0);
      for (int k = 1; k <= 19; k++) add(1, 0, 0, 3, 4'(k % 16), (k % 16) == 3, 0);
      add(0, 0, 0, 3, 3, 0, 0);
      add(0, 0, 0, 3, 3, 0, 0);
      add(0, 1, 1, 4, 0, 0, 0);
      for (int k = 1; k <= 11; k++) add(1, 0, 1, 4, 4'(k % 5), (k % 5) == 4, 0);
      add(0, 1, 1, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++) add(1, 0, 1, 0, 0, 1, 0);
      add(0, 1, 2, 6, 0, 0, 0);
      for (int k = 1; k <= 10; k++) add(1, 0, 2, 6, 4'(k < 6 ? k : 6), k == 6, k >= 6);
      add(1, 1, 2, 6, 0, 0, 0);
      for (int k = 1; k <= 3; k++) add(1, 0, 2, 6, 4'(k), 0, 0);
      for (int k = 4; k <= 9; k++) add(1, 0, 0, 12, 4'(k), 0, 0);
      add(1, 1, 0, 12, 0, 0, 0);
      add(1, 0, 0, 12, 1, 0, 0);
      add(0, 1, 2, 0, 0, 0, 0);
      add(1, 0, 2, 0, 0, 0, 1);
      add(1, 0, 2, 0, 0, 0, 1);
      add(0, 1, 3, 2, 0, 0, 0);
      for (int k = 1; k <= 3; k++) add(1, 0, 3, 2, 4'(k), k == 2, 0);
      for (int k = 4; k <= 19; k++)
         add(1, 0, 1, 1, 4'(k < 16 ? k : (k - 16) % 2), (k >= 16) && (k % 2 == 1), 0);
      n_main = vecs.size();
      // One-shot up to 5, leaving evt and done high for the reset check.
      add(0, 1, 2, 5, 0, 0, 0);
      for (int k = 1; k <= 5; k++) add(1, 0, 2, 5, 4'(k), k == 5, k == 5);
      n_rst = vecs.size();
      for (int k = 1; k <= 3; k++) add(1, 0, 0, 3, 4'(k), k == 3, 0);

      #12;
      check("reset cnt0", 32'(cnt[0]), 0);
      check("reset cnt1", 32'(cnt[1]), 0);
      check("reset evt", 32'(evt), 0);
      check("reset done", 32'(done), 0);
      rst_ni = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < n_rst; i++) run_vec(vecs[i], i);

      // Asynchronous reset in the middle of a cycle, no clock edge needed.
      rst_ni = 1'b0;
      en     = '0;
      #2;
      check("async rst cnt0", 32'(cnt[0]), 0);
      check("async rst evt0", 32'(evt[0]), 0);
      check("async rst done0", 32'(done[0]), 0);
      check("async rst cnt1", 32'(cnt[1]), 0);
      $display("async reset: ch0 cnt=%0d evt=%0d done=%0d ch1 cnt=%0d", cnt[0], evt[0], done[0], cnt[1]);
      @(posedge clk);
      @(negedge clk);
      rst_ni   = 1'b1;
      c1_model = 4'd0;
      for (int i = n_rst; i < vecs.size(); i++) run_vec(vecs[i], i);

`ifdef CNT_PRESCALER_EN
      // Prescaler: presc=2 stretches each step to 3 cycles, RELOAD cmp=1 gives evt every 6.
      en      = '0;
      clr     = 2'b01;
      mode[0] = 2'd1;
      cmp[0]  = 4'd1;
      presc   = 8'd2;
      @(posedge clk);
      #1;
      clr      = '0;
      en       = 2'b01;
      last_chg = -1;
      last_evt = -1;
      n_evt    = 0;
      prev_cnt = cnt[0];
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         if (cnt[0] != prev_cnt) begin
            if (last_chg >= 0) check("presc step spacing", 32'(c - last_chg), 3);
            last_chg = c;
            prev_cnt = cnt[0];
         end
         if (evt[0]) begin
            if (last_evt >= 0) check("presc evt spacing", 32'(c - last_evt), 6);
            last_evt = c;
            n_evt++;
         end
         $display("presc cycle %0d: cnt=%0d evt=%0d", c, cnt[0], evt[0]);
      end
      check("presc evt count>=3", 32'(n_evt >= 3), 1);
      presc = 8'd0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
      $fatal(1, "watchdog");
   end

endmodule
